// File: rtl/card_shoe_if.sv
// Card type shared by the shoe and the hand/board logic, plus the
// controller <-> shoe handshake interface. The controller side is the
// master (requests shuffles and draws); the shoe side is the slave.

package poker_types_pkg;

    // One playing card: rank 0..12 (deuce..ace), suit 0..3.
    typedef struct packed {
        logic [1:0] suit;
        logic [3:0] rank;
    } card_t;

endpackage

interface card_shoe_if
    import poker_types_pkg::*;
#(
    parameter int NUM_DECKS = 1
);
    localparam int N     = 52 * NUM_DECKS;
    localparam int CNT_W = $clog2(N + 1);

    logic             start_shuffle;
    logic             draw_card;
    card_t            top_card;
    logic             card_valid;
    logic             ready;
    logic             empty;
    logic [CNT_W-1:0] cards_left;
    logic             reshuffle_due;

    modport master (
        output start_shuffle,
        output draw_card,
        input  top_card,
        input  card_valid,
        input  ready,
        input  empty,
        input  cards_left,
        input  reshuffle_due
    );

    modport slave (
        input  start_shuffle,
        input  draw_card,
        output top_card,
        output card_valid,
        output ready,
        output empty,
        output cards_left,
        output reshuffle_due
    );

endinterface

// File: rtl/card_shoe.sv
// card_shoe: multi-deck card source. Fills the shoe in new-deck order after
// reset, shuffles it with an LFSR-driven swap shuffle that rejects
// out-of-range indices (so every position draws from a uniform range), and
// deals through a valid/draw handshake with a remaining-card count.
//
// Optional feature: define CARD_SHOE_CUT_CARD_EN to enable the cut card,
// which raises reshuffle_due once cards_left drops to CUT_REMAINING or
// below. Without the macro reshuffle_due is tied low.

module card_shoe
    import poker_types_pkg::*;
#(
    parameter int          NUM_DECKS     = 1,
    parameter logic [15:0] SEED          = 16'hACE1,
    parameter int          CUT_REMAINING = 0
) (
    input  logic        clk,
    input  logic        reset,
    card_shoe_if.slave  bus
);

    localparam int N     = 52 * NUM_DECKS;
    localparam int IDX_W = $clog2(N);
    localparam int CNT_W = $clog2(N + 1);

    // N is never a power of two, so pos can hold the value N once every
    // card has been dealt without widening the index.
    localparam logic [IDX_W-1:0] LAST_POS = IDX_W'(N - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(N);

    // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Elaboration-time guard against parameter values the shoe cannot support.
    if (SEED == 16'h0 || NUM_DECKS < 1 || NUM_DECKS > 8 ||
        CUT_REMAINING < 0 || CUT_REMAINING > N || IDX_W > 16) begin : g_bad_params
        $error("card_shoe: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        S_INIT,
        S_IDLE,
        S_SHUFFLE,
        S_DEAL
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] pos_q, pos_d;
    logic [CNT_W-1:0] cards_left_q, cards_left_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic [3:0]       init_rank_q;
    logic [1:0]       init_suit_q;

    logic [IDX_W-1:0] rnd_idx;
    logic             rnd_ok;
    logic             init_we;
    logic             swap_we;

    card_t deck [N];

    // Candidate swap index: low bits of the LFSR, rejected when past the end.
    assign rnd_idx = lfsr_q[IDX_W-1:0];
    assign rnd_ok  = (rnd_idx <= LAST_POS);

    // One Galois step per clock; the shoe never stops the generator.
    assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);

    // Next-state, deal position and card count for the shoe controller.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case leaves one unassigned and no latch is inferred.
        state_d      = state_q;
        pos_d        = pos_q;
        cards_left_d = cards_left_q;
        init_we      = 1'b0;
        swap_we      = 1'b0;

        case (state_q)
            S_INIT: begin
                init_we = 1'b1;
                if (pos_q == LAST_POS) begin
                    pos_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    pos_d = pos_q + IDX_W'(1);
                end
            end

            S_IDLE: begin
                if (bus.start_shuffle) begin
                    pos_d   = '0;
                    state_d = S_SHUFFLE;
                end
            end

            S_SHUFFLE: begin
                // A rejected sample just waits for the next LFSR value.
                if (rnd_ok) begin
                    swap_we = 1'b1;
                    if (pos_q == LAST_POS) begin
                        pos_d        = '0;
                        cards_left_d = FULL_CNT;
                        state_d      = S_DEAL;
                    end else begin
                        pos_d = pos_q + IDX_W'(1);
                    end
                end
            end

            S_DEAL: begin
                // A reshuffle request wins over a draw in the same cycle.
                if (bus.start_shuffle) begin
                    pos_d        = '0;
                    cards_left_d = '0;
                    state_d      = S_SHUFFLE;
                end else if (bus.draw_card && (cards_left_q != '0)) begin
                    pos_d        = pos_q + IDX_W'(1);
                    cards_left_d = cards_left_q - CNT_W'(1);
                end
            end

            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    // Controller state, position, count, LFSR and new-deck-order counters.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its neighbours.
        if (reset) begin
            state_q      <= S_INIT;
            pos_q        <= '0;
            cards_left_q <= '0;
            lfsr_q       <= SEED;
            init_rank_q  <= '0;
            init_suit_q  <= '0;
        end else begin
            state_q      <= state_d;
            pos_q        <= pos_d;
            cards_left_q <= cards_left_d;
            lfsr_q       <= lfsr_d;
            // rank = pos % 13, suit = (pos / 13) % 4; the 2-bit suit wraps
            // on its own and both counters land back on 0 at the end of INIT.
            if (init_we) begin
                if (init_rank_q == 4'd12) begin
                    init_rank_q <= '0;
                    init_suit_q <= init_suit_q + 2'd1;
                end else begin
                    init_rank_q <= init_rank_q + 4'd1;
                end
            end
        end
    end

    // Deck storage: new-deck fill during INIT, two-entry swap during SHUFFLE.
    always_ff @(posedge clk) begin
        // NOTE: the deck array has no reset; INIT rewrites every entry after
        // reset, so clearing it would only add a reset net to each bit.
        if (init_we) begin
            deck[pos_q] <= card_t'{suit: init_suit_q, rank: init_rank_q};
        end else if (swap_we) begin
            // Both reads see the old contents; when rnd_idx == pos_q the two
            // writes carry the same value and the entry is unchanged.
            deck[pos_q]   <= deck[rnd_idx];
            deck[rnd_idx] <= deck[pos_q];
        end
    end

    // Deal-side outputs are decodes of registered state only.
    assign bus.top_card   = (pos_q <= LAST_POS) ? deck[pos_q] : '0;
    assign bus.ready      = (state_q == S_DEAL);
    assign bus.card_valid = (state_q == S_DEAL) && (cards_left_q != '0);
    assign bus.empty      = (state_q == S_DEAL) && (cards_left_q == '0);
    assign bus.cards_left = cards_left_q;

`ifdef CARD_SHOE_CUT_CARD_EN
    logic reshuffle_due_q;

    // Cut-card flag tracks the next count, so it moves with cards_left and
    // drops as soon as the shoe leaves DEAL for a reshuffle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reshuffle_due_q <= 1'b0;
        end else begin
            reshuffle_due_q <= (state_d == S_DEAL) &&
                               (cards_left_d <= CNT_W'(CUT_REMAINING));
        end
    end

    assign bus.reshuffle_due = reshuffle_due_q;
`else
    assign bus.reshuffle_due = 1'b0;
`endif

endmodule

// File: tb/tb_card_shoe.sv
// Directed bench for card_shoe: one single-deck shoe (cut card at 20) and one
// double-deck shoe sharing clock and reset. A reference shuffle driven by a
// reference LFSR predicts every dealt card.

module tb_card_shoe;
    import poker_types_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    card_shoe_if #(.NUM_DECKS(1)) s1 ();
    card_shoe_if #(.NUM_DECKS(2)) s2 ();

    card_shoe #(.NUM_DECKS(1), .SEED(16'hACE1), .CUT_REMAINING(20)) dut1 (
        .clk   (clk),
        .reset (rst),
        .bus   (s1)
    );

    card_shoe #(.NUM_DECKS(2), .SEED(16'hACE1), .CUT_REMAINING(0)) dut2 (
        .clk   (clk),
        .reset (rst),
        .bus   (s2)
    );

    int total = 0;
    int bad   = 0;

    // Reference LFSR: x^16+x^14+x^13+x^11+1, Galois, right shift.
    logic [15:0] m_lfsr;
    always @(posedge clk or posedge rst) begin
        if (rst) m_lfsr <= 16'hACE1;
        else     m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    card_t m1 [52];
    card_t m2 [104];
    int    seen [52];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic card_t new_card(input int i);
        card_t c;
        c.rank = 4'(i % 13);
        c.suit = 2'((i / 13) % 4);
        return c;
    endfunction

    task automatic model_init();
        for (int i = 0; i < 52; i++)  m1[i] = new_card(i);
        for (int i = 0; i < 104; i++) m2[i] = new_card(i);
    endtask

    function automatic card_t top(input int sel);
        return (sel == 1) ? s1.top_card : s2.top_card;
    endfunction

    function automatic int left(input int sel);
        return (sel == 1) ? int'(s1.cards_left) : int'(s2.cards_left);
    endfunction

    function automatic logic rdy(input int sel);
        return (sel == 1) ? s1.ready : s2.ready;
    endfunction

    function automatic logic vld(input int sel);
        return (sel == 1) ? s1.card_valid : s2.card_valid;
    endfunction

    function automatic logic emp(input int sel);
        return (sel == 1) ? s1.empty : s2.empty;
    endfunction

    task automatic drive(input int sel, input logic start, input logic draw);
        if (sel == 1) begin
            s1.start_shuffle = start;
            s1.draw_card     = draw;
        end else begin
            s2.start_shuffle = start;
            s2.draw_card     = draw;
        end
    endtask

    // One-cycle start_shuffle (optionally with a draw that must be dropped),
    // then confirm the shoe has left DEAL/IDLE.
    task automatic pulse_start(input int sel, input logic with_draw, input string tag);
        drive(sel, 1'b1, with_draw);
        tick();
        drive(sel, 1'b0, 1'b0);
        check({tag, "_ready_low"}, 32'(rdy(sel)), 32'd0);
        check({tag, "_left_zero"}, 32'(left(sel)), 32'd0);
    endtask

    // Predict the shuffle one clock at a time from the reference LFSR, then
    // check the shoe is dealing a full shoe exactly when the model finishes.
    task automatic shuffle(input int sel, input bit noise, input string tag);
        int n;
        int pos;
        int r;
        int cyc;
        card_t t;
        n   = (sel == 1) ? 52 : 104;
        pos = 0;
        cyc = 0;
        while (pos < n && cyc < 4000) begin
            r = (sel == 1) ? int'(m_lfsr[5:0]) : int'(m_lfsr[6:0]);
            if (r < n) begin
                if (sel == 1) begin
                    t = m1[pos]; m1[pos] = m1[r]; m1[r] = t;
                end else begin
                    t = m2[pos]; m2[pos] = m2[r]; m2[r] = t;
                end
                pos++;
            end
            if (noise) drive(sel, cyc == 7, 1'b1);
            cyc++;
            tick();
        end
        drive(sel, 1'b0, 1'b0);
        check({tag, "_min_cycles"}, 32'(cyc >= n), 32'd1);
        check({tag, "_ready"},      32'(rdy(sel)), 32'd1);
        check({tag, "_left_full"},  32'(left(sel)), 32'(n));
        check({tag, "_valid"},      32'(vld(sel)), 32'd1);
        check({tag, "_not_empty"},  32'(emp(sel)), 32'd0);
    endtask

    // Back-to-back draws, checking every card against the model and tallying
    // rank/suit occurrences.
    task automatic deal(input int sel, input int count, input int start_left, input string tag);
        card_t c;
        card_t exp_c;
        int    idx;
        for (int i = 0; i < count; i++) begin
            c     = top(sel);
            exp_c = (sel == 1) ? m1[i] : m2[i];
            check($sformatf("%s_card%0d", tag, i), 32'(c), 32'(exp_c));
            check($sformatf("%s_left%0d", tag, i), 32'(left(sel)), 32'(start_left - i));
            if (sel == 1 && (left(sel) == 21 || left(sel) == 20)) begin
`ifdef CARD_SHOE_CUT_CARD_EN
                check($sformatf("%s_cut_at%0d", tag, left(sel)), 32'(s1.reshuffle_due),
                      32'(left(sel) <= 20));
`else
                check($sformatf("%s_cut_off%0d", tag, left(sel)), 32'(s1.reshuffle_due), 32'd0);
`endif
            end
            idx = int'(c.rank) * 4 + int'(c.suit);
            if (c.rank <= 4'd12) seen[idx]++;
            drive(sel, 1'b0, 1'b1);
            tick();
        end
        drive(sel, 1'b0, 1'b0);
    endtask

    task automatic clear_seen();
        for (int i = 0; i < 52; i++) seen[i] = 0;
    endtask

    task automatic check_seen(input int copies, input string tag);
        int ok;
        ok = 0;
        for (int i = 0; i < 52; i++) if (seen[i] == copies) ok++;
        check(tag, 32'(ok), 32'd52);
    endtask

    task automatic check_empty(input int sel, input string tag);
        check({tag, "_left"},  32'(left(sel)), 32'd0);
        check({tag, "_empty"}, 32'(emp(sel)),  32'd1);
        check({tag, "_valid"}, 32'(vld(sel)),  32'd0);
        check({tag, "_ready"}, 32'(rdy(sel)),  32'd1);
    endtask

    initial begin
        drive(1, 1'b0, 1'b0);
        drive(2, 1'b0, 1'b0);
        rst = 1'b1;
        repeat (3) tick();

        // Reset state of both shoes.
        check("rst1_ready", 32'(s1.ready),         32'd0);
        check("rst1_valid", 32'(s1.card_valid),    32'd0);
        check("rst1_empty", 32'(s1.empty),         32'd0);
        check("rst1_left",  32'(s1.cards_left),    32'd0);
        check("rst1_due",   32'(s1.reshuffle_due), 32'd0);
        check("rst2_ready", 32'(s2.ready),         32'd0);
        check("rst2_left",  32'(s2.cards_left),    32'd0);

        // Release; a start request during INIT must be ignored.
        rst = 1'b0;
        tick();
        drive(1, 1'b1, 1'b0);
        tick();
        drive(1, 1'b0, 1'b0);
        repeat (58) tick();
        check("init1_ready", 32'(s1.ready), 32'd0);
        check("init2_ready", 32'(s2.ready), 32'd0);
        repeat (140) tick();
        check("idle1_ready", 32'(s1.ready), 32'd0);
        check("idle1_left",  32'(s1.cards_left), 32'd0);
        check("idle2_ready", 32'(s2.ready), 32'd0);

        // Single deck: shuffle, deal all 52, confirm each card once.
        model_init();
        pulse_start(1, 1'b0, "sh1");
        shuffle(1, 1'b0, "sh1");
        clear_seen();
        deal(1, 52, 52, "d1");
        check_seen(1, "d1_unique");
        check_empty(1, "d1_end");

        // Draws while empty are ignored.
        for (int k = 0; k < 3; k++) begin
            drive(1, 1'b0, 1'b1);
            tick();
            drive(1, 1'b0, 1'b0);
            tick();
        end
        check_empty(1, "d1_overdraw");

        // Reshuffle from DEAL with a simultaneous draw; keep poking draw and
        // start during the shuffle, which must change nothing.
        pulse_start(1, 1'b1, "sh1b");
        check("sh1b_due_clear", 32'(s1.reshuffle_due), 32'd0);
        shuffle(1, 1'b1, "sh1b");
        deal(1, 5, 52, "d1b");

        // Double deck: shuffle, deal 104, each card exactly twice.
        pulse_start(2, 1'b0, "sh2");
        shuffle(2, 1'b0, "sh2");
        clear_seen();
        deal(2, 104, 104, "d2");
        check_seen(2, "d2_twice");
        check_empty(2, "d2_end");

        // Asynchronous reset in the middle of a shuffle.
        pulse_start(1, 1'b0, "sh1c");
        repeat (30) tick();
        #2 rst = 1'b1;
        #1;
        check("arst2_ready", 32'(s2.ready), 32'd0);
        check("arst2_empty", 32'(s2.empty), 32'd0);
        check("arst1_left",  32'(s1.cards_left), 32'd0);
        check("arst1_ready", 32'(s1.ready), 32'd0);
        tick();
        rst = 1'b0;
        model_init();
        repeat (55) tick();
        check("reinit1_ready", 32'(s1.ready), 32'd0);

        // The deck must be back in new-deck order before this shuffle.
        pulse_start(1, 1'b0, "sh1d");
        shuffle(1, 1'b0, "sh1d");
        clear_seen();
        deal(1, 52, 52, "d1d");
        check_seen(1, "d1d_unique");
        check_empty(1, "d1d_end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
